// File: rtl/enigma_pkg.sv
`default_nettype none
// ============================================================================
// enigma_pkg
// Shared letter types, stepper states and modular letter arithmetic.
// Rev 1.0
// ============================================================================
package enigma_pkg;

  localparam int ALPHABET_LEN = 26;
  localparam int PORTLEN      = 5;

  typedef logic [PORTLEN-1:0] letter_t;
  typedef logic [PORTLEN:0]   letter_wide_t;

  localparam letter_wide_t c_alen_wide = letter_wide_t'(ALPHABET_LEN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STEP    = 2'd1,
    PRESENT = 2'd2
  } stepper_state_t;

  // Operands are assumed already reduced, so one conditional subtract suffices.
  function automatic letter_t mod_add(input letter_t a, input letter_t b);
    letter_wide_t sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= c_alen_wide) begin
      sum = sum - c_alen_wide;
    end
    return sum[PORTLEN-1:0];
  endfunction

  function automatic logic is_legal(input letter_t v);
    return ({1'b0, v} < c_alen_wide);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rotor_position_counter.sv
`default_nettype none
// ============================================================================
// rotor_position_counter
// Mod-ALPHABET_LEN rotor position with load/step controls and a notch flag.
// Rev 1.0
// ============================================================================
module rotor_position_counter
  import enigma_pkg::*;
#(
  parameter letter_t NOTCH = '0,
  parameter letter_t INIT  = '0
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    step_i,
  input  logic    load_i,
  input  letter_t load_val_i,
  output letter_t pos_o,
  output logic    at_notch_o
);

  letter_t pos_q;
  letter_t pos_d;

  always_comb begin
    pos_d = pos_q;
    if (load_i) begin
      pos_d = load_val_i;
    end else if (step_i) begin
      pos_d = mod_add(pos_q, letter_t'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_q <= INIT;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos_o      = pos_q;
  assign at_notch_o = (pos_q == NOTCH);

endmodule
`default_nettype wire

// File: rtl/rotor_stepper.sv
`default_nettype none
// ============================================================================
// rotor_stepper
// Steps three rotors odometer-style (with double step) and presents the offset letter.
// Rev 1.0
// ============================================================================
module rotor_stepper #(
  parameter int ALPHABET_LEN = 26,
  parameter int PORTLEN      = 5,
  parameter int NOTCH_R0     = 21,
  parameter int NOTCH_R1     = 4,
  parameter int INIT_R0      = 0,
  parameter int INIT_R1      = 0,
  parameter int INIT_R2      = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_valid,
  input  logic [PORTLEN-1:0]   key_letter,
  output logic                 key_ready,
  input  logic                 load_en,
  input  logic [3*PORTLEN-1:0] load_pos,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PORTLEN-1:0]   input_letter,
  output logic                 re_cs_n,
  output logic [3*PORTLEN-1:0] pos_o,
  output logic                 error
);

  import enigma_pkg::*;

  if (PORTLEN != $clog2(ALPHABET_LEN)) begin : g_portlen_check
    $error("rotor_stepper: PORTLEN must equal clog2(ALPHABET_LEN)");
  end

  stepper_state_t state_q;
  letter_t        letter_q;
  letter_t        input_letter_q;
  logic           out_valid_q;
  logic           re_cs_n_q;
  logic           error_q;

  letter_t w_pos0, w_pos1, w_pos2;
  letter_t w_pos0_next;
  letter_t w_ld0, w_ld1, w_ld2;
  logic    w_notch0, w_notch1, w_r2_notch_unused;
  logic    w_load_go, w_load_bad, w_step;

  assign w_ld0 = load_pos[PORTLEN-1:0];
  assign w_ld1 = load_pos[2*PORTLEN-1:PORTLEN];
  assign w_ld2 = load_pos[3*PORTLEN-1:2*PORTLEN];

  assign w_load_go  = (state_q == IDLE) && load_en;
  assign w_load_bad = !is_legal(w_ld0) || !is_legal(w_ld1) || !is_legal(w_ld2);
  assign w_step     = (state_q == STEP);
  assign w_pos0_next = mod_add(w_pos0, letter_t'(1));

  // Middle rotor also steps when it sits on its own notch: the double step.
  rotor_position_counter #(.NOTCH(letter_t'(NOTCH_R0)), .INIT(letter_t'(INIT_R0))) u_r0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_i     (w_step),
    .load_i     (w_load_go),
    .load_val_i (is_legal(w_ld0) ? w_ld0 : letter_t'(0)),
    .pos_o      (w_pos0),
    .at_notch_o (w_notch0)
  );

  rotor_position_counter #(.NOTCH(letter_t'(NOTCH_R1)), .INIT(letter_t'(INIT_R1))) u_r1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_i     (w_step && (w_notch0 || w_notch1)),
    .load_i     (w_load_go),
    .load_val_i (is_legal(w_ld1) ? w_ld1 : letter_t'(0)),
    .pos_o      (w_pos1),
    .at_notch_o (w_notch1)
  );

  rotor_position_counter #(.NOTCH(letter_t'(0)), .INIT(letter_t'(INIT_R2))) u_r2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_i     (w_step && w_notch1),
    .load_i     (w_load_go),
    .load_val_i (is_legal(w_ld2) ? w_ld2 : letter_t'(0)),
    .pos_o      (w_pos2),
    .at_notch_o (w_r2_notch_unused)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      letter_q       <= '0;
      input_letter_q <= '0;
      out_valid_q    <= 1'b0;
      re_cs_n_q      <= 1'b1;
      error_q        <= 1'b0;
    end else begin
      error_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load_en) begin
            error_q <= w_load_bad;
          end else if (key_valid) begin
            if (is_legal(key_letter)) begin
              letter_q <= key_letter;
              state_q  <= STEP;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        // Counters step on this same edge, so offset by the post-step r0.
        STEP: begin
          input_letter_q <= mod_add(letter_q, w_pos0_next);
          out_valid_q    <= 1'b1;
          re_cs_n_q      <= 1'b0;
          state_q        <= PRESENT;
        end
        PRESENT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            re_cs_n_q   <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign key_ready    = rst_n && (state_q == IDLE) && !load_en;
  assign out_valid    = out_valid_q;
  assign re_cs_n      = re_cs_n_q;
  assign input_letter = input_letter_q;
  assign error        = error_q;
  assign pos_o        = {w_pos2, w_pos1, w_pos0};

endmodule
`default_nettype wire

// File: tb/tb_rotor_stepper.sv
`default_nettype none
// ============================================================================
// tb_rotor_stepper
// Directed self-checking bench for rotor_stepper.
// Rev 1.0
// ============================================================================
module tb_rotor_stepper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [4:0]  key_letter;
  logic        key_ready;
  logic        load_en;
  logic [14:0] load_pos;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  input_letter;
  logic        re_cs_n;
  logic [14:0] pos_o;
  logic        error;

  int n_checks = 0;
  int n_pass   = 0;

  rotor_stepper dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_letter   (key_letter),
    .key_ready    (key_ready),
    .load_en      (load_en),
    .load_pos     (load_pos),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .input_letter (input_letter),
    .re_cs_n      (re_cs_n),
    .pos_o        (pos_o),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] pk(input logic [4:0] r2, input logic [4:0] r1, input logic [4:0] r0);
    return {r2, r1, r0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] l);
    key_valid  = 1'b1;
    key_letter = l;
    tick();
    key_valid  = 1'b0;
  endtask

  task automatic do_load(input logic [14:0] p);
    load_en  = 1'b1;
    load_pos = p;
    tick();
    load_en  = 1'b0;
  endtask

  // Key accepted, one STEP cycle, then the presented letter; out_ready high consumes it.
  task automatic do_key(input string tag, input logic [4:0] l, input logic [4:0] exp_l,
                        input logic [14:0] exp_pos);
    press(l);
    check_val({tag, "_step_ov"}, out_valid, 0);
    tick();
    check_val({tag, "_ov"}, out_valid, 1);
    check_val({tag, "_letter"}, input_letter, exp_l);
    check_val({tag, "_pos"}, pos_o, exp_pos);
    tick();
    check_val({tag, "_idle_ov"}, out_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    key_valid  = 1'b0;
    key_letter = '0;
    load_en    = 1'b0;
    load_pos   = '0;
    out_ready  = 1'b1;
    tick();
    tick();
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_re_cs_n", re_cs_n, 1);
    check_val("rst_letter", input_letter, 0);
    check_val("rst_error", error, 0);
    check_val("rst_pos", pos_o, 0);
    check_val("rst_key_ready", key_ready, 0);
    rst_n = 1'b1;
    #1;
    check_val("idle_key_ready", key_ready, 1);

    // First key: r0 0->1, letter 0+1.
    press(5'd0);
    check_val("k0_step_ov", out_valid, 0);
    check_val("k0_step_ready", key_ready, 0);
    tick();
    check_val("k0_ov", out_valid, 1);
    check_val("k0_cs", re_cs_n, 0);
    check_val("k0_letter", input_letter, 1);
    check_val("k0_pos", pos_o, pk(0, 0, 1));
    tick();
    check_val("k0_done_ov", out_valid, 0);
    check_val("k0_done_cs", re_cs_n, 1);
    check_val("k0_done_ready", key_ready, 1);

    // Double step: ADU -> ADV -> AEW -> BFX.
    do_load(pk(0, 3, 20));
    check_val("ds_load_pos", pos_o, pk(0, 3, 20));
    do_key("ds1", 5'd0, 5'd21, pk(0, 3, 21));
    do_key("ds2", 5'd0, 5'd22, pk(0, 4, 22));
    do_key("ds3", 5'd0, 5'd23, pk(1, 5, 23));

    // Wrap of r0 with notches unmet.
    do_load(pk(25, 25, 25));
    do_key("wrap", 5'd24, 5'd24, pk(25, 25, 0));

    // Backpressure: presented letter 3+1=4 must hold.
    out_ready = 1'b0;
    press(5'd3);
    tick();
    key_valid  = 1'b1;
    key_letter = 5'd7;
    for (int i = 0; i < 5; i++) begin
      check_val("bp_ov", out_valid, 1);
      check_val("bp_letter", input_letter, 4);
      check_val("bp_pos", pos_o, pk(25, 25, 1));
      check_val("bp_key_ready", key_ready, 0);
      check_val("bp_cs", re_cs_n, 0);
      tick();
    end
    key_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check_val("bp_release_ov", out_valid, 0);
    check_val("bp_release_pos", pos_o, pk(25, 25, 1));

    // Illegal key.
    press(5'd27);
    check_val("badkey_err", error, 1);
    check_val("badkey_ov", out_valid, 0);
    check_val("badkey_pos", pos_o, pk(25, 25, 1));
    tick();
    check_val("badkey_err_pulse", error, 0);
    check_val("badkey_ov2", out_valid, 0);
    check_val("badkey_ready", key_ready, 1);

    // Illegal load field.
    do_load(pk(2, 3, 30));
    check_val("badload_err", error, 1);
    check_val("badload_pos", pos_o, pk(2, 3, 0));
    tick();
    check_val("badload_err_pulse", error, 0);

    // Load and key in the same cycle: load wins, key ignored.
    load_en    = 1'b1;
    load_pos   = pk(1, 1, 1);
    key_valid  = 1'b1;
    key_letter = 5'd5;
    #1;
    check_val("lk_key_ready", key_ready, 0);
    tick();
    load_en   = 1'b0;
    key_valid = 1'b0;
    check_val("lk_pos", pos_o, pk(1, 1, 1));
    check_val("lk_err", error, 0);
    tick();
    check_val("lk_no_ov", out_valid, 0);
    check_val("lk_pos2", pos_o, pk(1, 1, 1));

    // Reset while presenting.
    out_ready = 1'b0;
    press(5'd2);
    tick();
    check_val("mr_ov", out_valid, 1);
    check_val("mr_letter", input_letter, 4);
    rst_n = 1'b0;
    tick();
    check_val("mr_ov_rst", out_valid, 0);
    check_val("mr_cs_rst", re_cs_n, 1);
    check_val("mr_pos_rst", pos_o, 0);
    check_val("mr_letter_rst", input_letter, 0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    do_key("post_rst", 5'd25, 5'd0, pk(0, 0, 1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
